// File: rtl/video_out_stage.sv
// Video output formatter: post-resync AV-mute, optional OSD overlay, fixed 2-cycle latency.
// Build option: define VIDOUT_OSD_EN to enable the OSD overlay in stage 2.
module video_out_stage #(
  parameter int MUTE_FRAMES = 4,
  parameter int FCNT_W      = 16
) (
  input  logic              PCLK_i,
  input  logic              reset_n,
  input  logic [7:0]        R_i,
  input  logic [7:0]        G_i,
  input  logic [7:0]        B_i,
  input  logic              HSYNC_i,
  input  logic              VSYNC_i,
  input  logic              DE_i,
  input  logic              osd_enable,
  input  logic [1:0]        osd_color,
  input  logic              resync_strobe_i,
  input  logic              mute_force,
  output logic [7:0]        R_o,
  output logic [7:0]        G_o,
  output logic [7:0]        B_o,
  output logic              HSYNC_o,
  output logic              VSYNC_o,
  output logic              DE_o,
  output logic              muted_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);
  // state  | meaning
  // S_MUTE | video blanked; mcnt counts remaining frame starts
  // S_RUN  | live video
  typedef enum logic {S_MUTE, S_RUN} state_t;

  localparam int MCNT_W = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;

  state_t              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                vs_prev_q, vs_prev_d;
  logic [23:0]         rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic                hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic                hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic                osd_en1_q, osd_en1_d;
  logic [1:0]          osd_col1_q, osd_col1_d;
  logic                frame_start, reload, muted;

  assign frame_start = ~VSYNC_i & vs_prev_q;
  assign reload      = resync_strobe_i | mute_force;
  assign muted       = (state_q == S_MUTE);

  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    vs_prev_d   = VSYNC_i;
    frame_cnt_d = frame_start ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    case (state_q)
      S_MUTE: begin
        if (reload) begin
          mcnt_d = MCNT_W'(MUTE_FRAMES);
        end else if (frame_start) begin
          if (mcnt_q <= MCNT_W'(1)) state_d = S_RUN;
          else                      mcnt_d  = mcnt_q - MCNT_W'(1);
        end
      end
      S_RUN: begin
        if (reload) begin
          state_d = S_MUTE;
          mcnt_d  = MCNT_W'(MUTE_FRAMES);
        end
      end
      default: state_d = S_MUTE;
    endcase
  end

  // Stage 1 blanks on the registered state, so a state change shows from the next pixel.
  always_comb begin
    rgb1_d     = muted ? 24'h000000 : {R_i, G_i, B_i};
    hs1_d      = HSYNC_i;
    vs1_d      = VSYNC_i;
    de1_d      = DE_i;
    osd_en1_d  = osd_enable;
    osd_col1_d = osd_color;
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;
    de2_d      = de1_q;
    rgb2_d     = rgb1_q;
`ifdef VIDOUT_OSD_EN
    if (osd_en1_q) begin
      case (osd_col1_q)
        2'd0:    rgb2_d = 24'h000000;
        2'd1:    rgb2_d = 24'h0000ff;
        2'd2:    rgb2_d = 24'hffff00;
        default: rgb2_d = 24'hffffff;
      endcase
    end
`endif
  end

  always_ff @(posedge PCLK_i) begin
    if (!reset_n) begin
      state_q     <= S_MUTE;
      mcnt_q      <= MCNT_W'(MUTE_FRAMES);
      frame_cnt_q <= '0;
      vs_prev_q   <= 1'b1;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      de1_q       <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      de2_q       <= 1'b0;
      osd_en1_q   <= 1'b0;
      osd_col1_q  <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      frame_cnt_q <= frame_cnt_d;
      vs_prev_q   <= vs_prev_d;
      rgb1_q      <= rgb1_d;
      rgb2_q      <= rgb2_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      de1_q       <= de1_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      de2_q       <= de2_d;
      osd_en1_q   <= osd_en1_d;
      osd_col1_q  <= osd_col1_d;
    end
  end

`ifndef VIDOUT_OSD_EN
  logic unused_osd;
  assign unused_osd = ^{osd_en1_q, osd_col1_q};
`endif

  assign {R_o, G_o, B_o} = rgb2_q;
  assign HSYNC_o         = hs2_q;
  assign VSYNC_o         = vs2_q;
  assign DE_o            = de2_q;
  assign muted_o         = muted;
  assign frame_cnt_o     = frame_cnt_q;
endmodule

// File: tb/tb_video_out_stage.sv
// Directed bench for video_out_stage; a second narrow instance covers counter wrap and MUTE_FRAMES=0.
module tb_video_out_stage;
  logic        PCLK_i = 1'b0;
  logic        reset_n;
  logic [7:0]  R_i, G_i, B_i;
  logic        HSYNC_i, VSYNC_i, DE_i;
  logic        osd_enable;
  logic [1:0]  osd_color;
  logic        resync_strobe_i, mute_force;
  logic [7:0]  R_o, G_o, B_o;
  logic        HSYNC_o, VSYNC_o, DE_o, muted_o;
  logic [15:0] frame_cnt_o;
  logic [7:0]  unused_r_w, unused_g_w, unused_b_w;
  logic        unused_hs_w, unused_vs_w, unused_de_w;
  logic        muted_w;
  logic [3:0]  fcnt_w;

  int checks = 0;
  int errors = 0;

  always #5 PCLK_i = ~PCLK_i;

  video_out_stage #(.MUTE_FRAMES(4), .FCNT_W(16)) u_dut (
    .PCLK_i(PCLK_i), .reset_n(reset_n), .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .osd_enable(osd_enable), .osd_color(osd_color),
    .resync_strobe_i(resync_strobe_i), .mute_force(mute_force),
    .R_o(R_o), .G_o(G_o), .B_o(B_o), .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o),
    .DE_o(DE_o), .muted_o(muted_o), .frame_cnt_o(frame_cnt_o));

  video_out_stage #(.MUTE_FRAMES(0), .FCNT_W(4)) u_dut_w (
    .PCLK_i(PCLK_i), .reset_n(reset_n), .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .osd_enable(osd_enable), .osd_color(osd_color),
    .resync_strobe_i(resync_strobe_i), .mute_force(mute_force),
    .R_o(unused_r_w), .G_o(unused_g_w), .B_o(unused_b_w), .HSYNC_o(unused_hs_w),
    .VSYNC_o(unused_vs_w), .DE_o(unused_de_w), .muted_o(muted_w), .frame_cnt_o(fcnt_w));

  task automatic tick();
    @(posedge PCLK_i);
    #1;
  endtask

  // One short frame: frame start in the first cycle, then two cycles of VSYNC high.
  task automatic vs_frame();
    VSYNC_i = 1'b0; tick();
    VSYNC_i = 1'b1; tick(); tick();
  endtask

  function automatic logic [23:0] exp_pix(input logic en, input logic [1:0] col,
                                          input logic [23:0] base);
`ifdef VIDOUT_OSD_EN
    if (en) begin
      case (col)
        2'd0: return 24'h000000;
        2'd1: return 24'h0000ff;
        2'd2: return 24'hffff00;
        default: return 24'hffffff;
      endcase
    end
`endif
    return base;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    {R_i, G_i, B_i} = 24'haabbcc; HSYNC_i = 1'b0; VSYNC_i = 1'b0; DE_i = 1'b1;
    osd_enable = 1'b1; osd_color = 2'd3; resync_strobe_i = 1'b0; mute_force = 1'b0;
    tick(); tick();
    checks++;
    if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, muted_o} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b de=%b muted=%b, expected rgb=000000 hs=1 vs=1 de=0 muted=1",
               {R_o, G_o, B_o}, HSYNC_o, VSYNC_o, DE_o, muted_o);
    end
    checks++;
    if (frame_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt_o);
    end
    {R_i, G_i, B_i} = 24'h555555; HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0;
    osd_enable = 1'b0; osd_color = 2'd0;
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if ({muted_o, R_o} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL post_reset_muted: got muted=%b R=%h expected muted=1 R=00", muted_o, R_o);
    end
  endtask

  task automatic test_unmute();
    vs_frame(); vs_frame(); vs_frame();
    checks++;
    if ({muted_o, R_o, frame_cnt_o} !== {1'b1, 8'h00, 16'd3}) begin
      errors++; $display("FAIL unmute_after3: got muted=%b R=%h fcnt=%0d expected 1 00 3", muted_o, R_o, frame_cnt_o);
    end
    VSYNC_i = 1'b0; {R_i, G_i, B_i} = 24'h444444; tick();
    checks++;
    if (muted_o !== 1'b0) begin
      errors++; $display("FAIL unmute_state: got muted=%b expected 0", muted_o);
    end
    VSYNC_i = 1'b1; {R_i, G_i, B_i} = 24'h666666; tick();
    checks++;
    if ({R_o, G_o, B_o} !== 24'h000000) begin
      errors++; $display("FAIL unmute_fs_pixel_blank: got %h expected 000000", {R_o, G_o, B_o});
    end
    {R_i, G_i, B_i} = 24'h777777; tick();
    checks++;
    if ({R_o, G_o, B_o} !== 24'h666666) begin
      errors++; $display("FAIL unmute_first_live: got %h expected 666666", {R_o, G_o, B_o});
    end
    vs_frame(); vs_frame();
    checks++;
    if (frame_cnt_o !== 16'd6) begin
      errors++; $display("FAIL unmute_frame_cnt: got %0d expected 6", frame_cnt_o);
    end
  endtask

  task automatic test_resync();
    {R_i, G_i, B_i} = 24'h123456; resync_strobe_i = 1'b1; tick();
    checks++;
    if (muted_o !== 1'b1) begin
      errors++; $display("FAIL resync_muted_next: got %b expected 1", muted_o);
    end
    resync_strobe_i = 1'b0; {R_i, G_i, B_i} = 24'h9abcde; tick();
    checks++;
    if ({R_o, G_o, B_o} !== 24'h123456) begin
      errors++; $display("FAIL resync_pixel_live: got %h expected 123456", {R_o, G_o, B_o});
    end
    {R_i, G_i, B_i} = 24'h010203; tick();
    checks++;
    if ({R_o, G_o, B_o} !== 24'h000000) begin
      errors++; $display("FAIL resync_next_blank: got %h expected 000000", {R_o, G_o, B_o});
    end
    vs_frame(); vs_frame(); vs_frame();
    checks++;
    if (muted_o !== 1'b1) begin
      errors++; $display("FAIL resync_still_muted3: got %b expected 1", muted_o);
    end
    vs_frame();
    checks++;
    if ({muted_o, R_o, G_o, B_o} !== {1'b0, 24'h010203}) begin
      errors++; $display("FAIL resync_unmute4: got muted=%b rgb=%h expected 0 010203", muted_o, {R_o, G_o, B_o});
    end
  endtask

  task automatic test_coincide();
    resync_strobe_i = 1'b1; tick(); resync_strobe_i = 1'b0;
    vs_frame(); vs_frame(); vs_frame();
    VSYNC_i = 1'b0; resync_strobe_i = 1'b1; tick();
    resync_strobe_i = 1'b0; VSYNC_i = 1'b1; tick(); tick();
    checks++;
    if (muted_o !== 1'b1) begin
      errors++; $display("FAIL coincide_stays_muted: got %b expected 1", muted_o);
    end
    vs_frame(); vs_frame(); vs_frame();
    checks++;
    if (muted_o !== 1'b1) begin
      errors++; $display("FAIL coincide_reloaded: got %b expected 1", muted_o);
    end
    vs_frame();
    checks++;
    if (muted_o !== 1'b0) begin
      errors++; $display("FAIL coincide_unmute: got %b expected 0", muted_o);
    end
  endtask

  task automatic test_force_wrap();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    checks++;
    if ({frame_cnt_o, fcnt_w} !== {16'd0, 4'd0}) begin
      errors++; $display("FAIL force_reset_cnt: got %0d/%0d expected 0/0", frame_cnt_o, fcnt_w);
    end
    mute_force = 1'b1;
    for (int i = 0; i < 10; i++) vs_frame();
    checks++;
    if ({muted_o, muted_w, frame_cnt_o, fcnt_w} !== {1'b1, 1'b1, 16'd10, 4'd10}) begin
      errors++; $display("FAIL force_held: got muted=%b/%b cnt=%0d/%0d expected 1/1 10/10",
                         muted_o, muted_w, frame_cnt_o, fcnt_w);
    end
    mute_force = 1'b0; tick();
    vs_frame();
    checks++;
    if ({muted_o, muted_w} !== 2'b10) begin
      errors++; $display("FAIL force_release_f11: got muted=%b/%b expected 1/0", muted_o, muted_w);
    end
    vs_frame(); vs_frame();
    checks++;
    if (muted_o !== 1'b1) begin
      errors++; $display("FAIL force_release_f13: got %b expected 1", muted_o);
    end
    vs_frame();
    checks++;
    if ({muted_o, frame_cnt_o} !== {1'b0, 16'd14}) begin
      errors++; $display("FAIL force_release_f14: got muted=%b cnt=%0d expected 0 14", muted_o, frame_cnt_o);
    end
    vs_frame();
    checks++;
    if (fcnt_w !== 4'hf) begin
      errors++; $display("FAIL wrap_all_ones: got %h expected f", fcnt_w);
    end
    vs_frame();
    checks++;
    if ({fcnt_w, frame_cnt_o} !== {4'h0, 16'd16}) begin
      errors++; $display("FAIL wrap_zero: got %h/%0d expected 0/16", fcnt_w, frame_cnt_o);
    end
  endtask

  task automatic test_osd();
    logic        en  [0:7];
    logic [1:0]  col [0:7];
    logic [23:0] exp [0:7];
    en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    col = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 8; i++) exp[i] = exp_pix(en[i], col[i], (i < 5) ? 24'h000000 : 24'h555555);
    {R_i, G_i, B_i} = 24'h555555;
    mute_force = 1'b1; tick();
    for (int i = 0; i <= 5; i++) begin
      if (i == 5) begin
        osd_enable = 1'b0; mute_force = 1'b0;
      end else begin
        osd_enable = en[i]; osd_color = col[i];
      end
      tick();
      if (i >= 1) begin
        checks++;
        if ({R_o, G_o, B_o} !== exp[i-1]) begin
          errors++; $display("FAIL osd_muted_%0d: got %h expected %h", i - 1, {R_o, G_o, B_o}, exp[i-1]);
        end
      end
    end
    vs_frame(); vs_frame(); vs_frame(); vs_frame();
    for (int i = 5; i <= 8; i++) begin
      if (i == 8) osd_enable = 1'b0;
      else begin
        osd_enable = en[i]; osd_color = col[i];
      end
      tick();
      if (i >= 6) begin
        checks++;
        if ({R_o, G_o, B_o} !== exp[i-1]) begin
          errors++; $display("FAIL osd_live_%0d: got %h expected %h", i - 1, {R_o, G_o, B_o}, exp[i-1]);
        end
      end
    end
  endtask

  task automatic test_sync_delay();
    logic [2:0] hist [0:39];
    for (int i = 0; i < 40; i++) begin
      hist[i] = 3'($urandom_range(0, 7));
      {HSYNC_i, VSYNC_i, DE_i} = hist[i];
      tick();
      if (i >= 1) begin
        checks++;
        if ({HSYNC_o, VSYNC_o, DE_o} !== hist[i-1]) begin
          errors++; $display("FAIL sync_delay_%0d: got %b expected %b", i, {HSYNC_o, VSYNC_o, DE_o}, hist[i-1]);
        end
      end
    end
    {R_i, G_i, B_i} = 24'hfedcba; HSYNC_i = 1'b0; VSYNC_i = 1'b0; DE_i = 1'b1;
    tick();
    reset_n = 1'b0; tick();
    checks++;
    if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, muted_o, frame_cnt_o} !==
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL midline_reset: got rgb=%h hs=%b vs=%b de=%b muted=%b cnt=%0d",
                         {R_o, G_o, B_o}, HSYNC_o, VSYNC_o, DE_o, muted_o, frame_cnt_o);
    end
    VSYNC_i = 1'b1; reset_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_unmute();
    test_resync();
    test_coincide();
    test_force_wrap();
    test_osd();
    test_sync_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
